// File: rtl/mem_port_arbiter_2ch.sv
// +------------------------------------------------------------------------+
// | mem_port_arbiter_2ch                                                   |
// | Round-robin arbiter joining two byte-lane masters onto one byte RAM.   |
// | Optional statistics counters: define ARB_STATS_EN.                     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module mem_port_arbiter_2ch #(
    parameter int ADDR_W       = 14,
    parameter int BASE_ADDR    = 0,
    parameter int MEM_SIZE     = 1024,
    parameter int MEM_AW       = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          req_oe,
    input  logic [1:0]          req_we,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [15:0]         req_wdata,
    input  logic [7:0]          req_size,
    output logic [15:0]         rsp_rdata,
    output logic [1:0]          rsp_datardy,
    output logic                mem_oe,
    output logic                mem_we,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic [7:0]          mem_wdata,
    output logic [7:0]          mem_wmask,
    input  logic [7:0]          mem_rdata,
    output logic                err
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]         stat_grants0,
    output logic [31:0]         stat_grants1,
    output logic [31:0]         stat_wait0,
    output logic [31:0]         stat_wait1
`endif
);

    localparam int                c_cnt_w   = $clog2(READ_LATENCY + 1);
    localparam logic [ADDR_W:0]   c_win_lo  = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0]   c_win_sz  = (ADDR_W+1)'(MEM_SIZE);
    localparam logic [c_cnt_w-1:0] c_rl     = c_cnt_w'(READ_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                ch_q, ch_d;
    logic                last_grant_q, last_grant_d;
    logic                wr_q, wr_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [7:0]          mask_q, mask_d;
    logic [c_cnt_w-1:0]  cnt_q, cnt_d;
    logic                err_q, err_d;

    logic [1:0]          w_valid;
    logic [1:0]          w_conflict;
    logic [ADDR_W:0]     w_off [2];
    logic                w_grant_any;
    logic                w_grant_ch;

    // Borrow-based window test keeps the compare exact even when the window
    // ends at 2^ADDR_W.
    for (genvar i = 0; i < 2; i++) begin : g_ch
        logic [ADDR_W+1:0] diff;
        logic              in_win;
        assign diff          = {2'b00, req_addr[i*ADDR_W +: ADDR_W]} - {1'b0, c_win_lo};
        assign w_off[i]      = diff[ADDR_W:0];
        assign in_win        = !diff[ADDR_W+1] && (diff[ADDR_W:0] < c_win_sz);
        assign w_valid[i]    = (req_oe[i] ^ req_we[i]) & in_win;
        assign w_conflict[i] = req_oe[i] & req_we[i] & in_win;
    end

    assign w_grant_any = |w_valid;
    assign w_grant_ch  = (w_valid == 2'b11) ? ~last_grant_q : w_valid[1];

    function automatic logic [7:0] size_to_mask(input logic [3:0] s);
        logic [8:0] m;
        m = (9'd1 << s) - 9'd1;
        if (s >= 4'd8) begin
            return 8'hFF;
        end
        return m[7:0];
    endfunction

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        last_grant_d = last_grant_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        cnt_d        = cnt_q;
        err_d        = err_q | (|w_conflict);
        mem_oe       = 1'b0;
        mem_we       = 1'b0;
        rsp_datardy  = 2'b00;
        rsp_rdata    = 16'h0000;
        case (state_q)
            ST_IDLE: begin
                if (w_grant_any) begin
                    ch_d         = w_grant_ch;
                    last_grant_d = w_grant_ch;
                    wr_d         = req_we[w_grant_ch];
                    addr_d       = w_off[w_grant_ch][MEM_AW-1:0];
                    wdata_d      = req_wdata[8*w_grant_ch +: 8];
                    mask_d       = size_to_mask(req_size[4*w_grant_ch +: 4]);
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_oe = !wr_q;
                mem_we = wr_q;
                if (wr_q) begin
                    rsp_datardy[ch_q] = 1'b1;
                    state_d           = ST_IDLE;
                end else begin
                    cnt_d   = c_cnt_w'(1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == c_rl) begin
                    rsp_datardy[ch_q]       = 1'b1;
                    rsp_rdata[8*ch_q +: 8]  = mem_rdata;
                    state_d                 = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ch_q         <= 1'b0;
            last_grant_q <= 1'b1;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 8'h00;
            mask_q       <= 8'h00;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = mask_q;
    assign err       = err_q;

`ifdef ARB_STATS_EN
    logic [31:0] grants_q [2];
    logic [31:0] grants_d [2];
    logic [31:0] wait_q   [2];
    logic [31:0] wait_d   [2];
    logic [1:0]  w_granted;
    logic [1:0]  w_active;

    for (genvar i = 0; i < 2; i++) begin : g_stat
        assign w_granted[i] = (state_q == ST_IDLE) && w_grant_any && (w_grant_ch == 1'(i));
        assign w_active[i]  = w_granted[i] || ((state_q != ST_IDLE) && (ch_q == 1'(i)));
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            grants_d[i] = grants_q[i];
            wait_d[i]   = wait_q[i];
            if (w_granted[i] && (grants_q[i] != 32'hFFFF_FFFF)) begin
                grants_d[i] = grants_q[i] + 32'd1;
            end
            if (w_valid[i] && !w_active[i] && (wait_q[i] != 32'hFFFF_FFFF)) begin
                wait_d[i] = wait_q[i] + 32'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                grants_q[i] <= 32'd0;
                wait_q[i]   <= 32'd0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                grants_q[i] <= grants_d[i];
                wait_q[i]   <= wait_d[i];
            end
        end
    end

    assign stat_grants0 = grants_q[0];
    assign stat_grants1 = grants_q[1];
    assign stat_wait0   = wait_q[0];
    assign stat_wait1   = wait_q[1];
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter_2ch.sv
// +------------------------------------------------------------------------+
// | tb_mem_port_arbiter_2ch                                                |
// | Scoreboard bench for mem_port_arbiter_2ch with a behavioural byte RAM. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_arbiter_2ch;

    localparam int ADDR_W = 14;
    localparam int BASE   = 0;
    localparam int MSZ    = 1024;
    localparam int MEM_AW = 10;
    localparam int RL     = 2;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [1:0]          req_oe = '0;
    logic [1:0]          req_we = '0;
    logic [2*ADDR_W-1:0] req_addr = '0;
    logic [15:0]         req_wdata = '0;
    logic [7:0]          req_size = '0;
    logic [15:0]         rsp_rdata;
    logic [1:0]          rsp_datardy;
    logic                mem_oe, mem_we;
    logic [MEM_AW-1:0]   mem_addr;
    logic [7:0]          mem_wdata, mem_wmask, mem_rdata;
    logic                err;
`ifdef ARB_STATS_EN
    logic [31:0]         stat_grants0, stat_grants1, stat_wait0, stat_wait1;
`endif

    always #5 clock = ~clock;

    mem_port_arbiter_2ch #(
        .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MEM_SIZE(MSZ),
        .MEM_AW(MEM_AW), .READ_LATENCY(RL)
    ) dut (
        .clock(clock), .reset(reset),
        .req_oe(req_oe), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size),
        .rsp_rdata(rsp_rdata), .rsp_datardy(rsp_datardy),
        .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
        .err(err)
`ifdef ARB_STATS_EN
        ,
        .stat_grants0(stat_grants0), .stat_grants1(stat_grants1),
        .stat_wait0(stat_wait0), .stat_wait1(stat_wait1)
`endif
    );

    // Behavioural RAM: bit-masked writes, two-stage read pipeline.
    logic [7:0] ram [0:1023];
    logic [7:0] rd_p1, rd_p2;
    assign mem_rdata = rd_p2;
    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= (ram[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
        rd_p1 <= mem_oe ? ram[mem_addr] : 8'h00;
        rd_p2 <= rd_p1;
    end

    typedef struct {
        logic       ch;
        logic       rd;
        logic [7:0] data;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] shadow [0:1023];
    int         checks = 0;
    int         errors = 0;
    time        dr_t0 = 0;
    time        dr_t1 = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_mask(input logic [3:0] s);
        if (s >= 4'd8) return 8'hFF;
        return 8'hFF >> (4'd8 - s);
    endfunction

    always @(negedge clock) begin : mon
        exp_t e;
        if (!reset && rsp_datardy != 2'b00) begin
            if (rsp_datardy[0]) dr_t0 = $time;
            if (rsp_datardy[1]) dr_t1 = $time;
            if (sb.size() == 0) begin
                chk("dr_unexpected", 32'(rsp_datardy), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("dr_ch", 32'(rsp_datardy), e.ch ? 32'd2 : 32'd1);
                if (e.rd) chk("rdata", 32'(rsp_rdata), e.ch ? {16'h0, e.data, 8'h00} : {24'h0, e.data});
                else      chk("wr_rdata0", 32'(rsp_rdata), 32'd0);
            end
        end
    end

    task automatic reset_dut();
        @(posedge clock); #1;
        reset = 1'b1;
        sb.delete();
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic do_req(input int ch, input bit wr, input int a, input logic [7:0] wd, input logic [3:0] sz);
        exp_t e;
        bit   seen;
        int   n;
        e.ch   = ch[0];
        e.rd   = !wr;
        e.data = shadow[a];
        if (wr) shadow[a] = (shadow[a] & ~exp_mask(sz)) | (wd & exp_mask(sz));
        sb.push_back(e);
        req_oe[ch] = !wr;
        req_we[ch] = wr;
        req_addr[ch*ADDR_W +: ADDR_W] = a[ADDR_W-1:0];
        req_wdata[ch*8 +: 8] = wd;
        req_size[ch*4 +: 4]  = sz;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            seen = mem_oe | mem_we;
        end
        chk("strobe_seen", 32'(seen), 32'd1);
        if (seen) begin
            chk("mem_addr", 32'(mem_addr), 32'(a - BASE));
            chk("mem_dir", {30'd0, mem_oe, mem_we}, wr ? 32'd1 : 32'd2);
            if (wr) begin
                chk("mem_wmask", 32'(mem_wmask), 32'(exp_mask(sz)));
                chk("mem_wdata", 32'(mem_wdata), 32'(wd));
            end
        end
        n = 0;
        while (!rsp_datardy[ch] && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("dr_latency", n, wr ? 32'd0 : 32'(RL));
        @(posedge clock); #1;
        req_oe[ch] = 1'b0;
        req_we[ch] = 1'b0;
    endtask

    initial begin : wdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        exp_t e;
        for (int i = 0; i < 1024; i++) shadow[i] = 8'h00;

        #2;
        chk("rst_rsp", {14'd0, rsp_rdata, rsp_datardy}, 32'd0);
        chk("rst_mem", {4'd0, mem_oe, mem_we, mem_addr, mem_wdata, mem_wmask}, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Single write, then mask-size boundaries and readback.
        do_req(0, 1, 5, 8'hA5, 4'd8);
        do_req(1, 0, 5, 8'h00, 4'd8);
        do_req(1, 1, 50, 8'hF0, 4'd8);
        do_req(1, 1, 50, 8'h0F, 4'd3);
        do_req(0, 1, 50, 8'hFF, 4'd0);
        do_req(0, 0, 50, 8'h00, 4'd8);
        do_req(0, 1, 1023, 8'h3C, 4'd4);
        do_req(1, 0, 1023, 8'h00, 4'd8);
        do_req(0, 1, 20, 8'h11, 4'd15);
        do_req(1, 1, 30, 8'h22, 4'd8);
        do_req(0, 1, 40, 8'h33, 4'd8);

        // Simultaneous reads right after reset: channel 0 wins first.
        reset_dut();
        e.rd = 1'b1;
        e.ch = 1'b0; e.data = shadow[20]; sb.push_back(e);
        e.ch = 1'b1; e.data = shadow[30]; sb.push_back(e);
        req_addr = {14'd30, 14'd20};
        req_oe   = 2'b11;
        cnt = 0;
        while (!rsp_datardy[0] && cnt < 20) begin @(negedge clock); cnt++; end
        @(posedge clock); #1;
        req_oe[0] = 1'b0;
        cnt = 0;
        while (!rsp_datardy[1] && cnt < 20) begin @(negedge clock); cnt++; end
        @(posedge clock); #1;
        req_oe[1] = 1'b0;
        chk("rd_gap", 32'(dr_t1 - dr_t0), 32'd40);
        chk("sb_drained2", sb.size(), 32'd0);

        // Just outside the window: never served, no error.
        req_addr[ADDR_W +: ADDR_W] = 14'(BASE + MSZ);
        req_oe[1] = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (mem_oe || mem_we || rsp_datardy != 2'b00) cnt++;
        end
        chk("oow_activity", cnt, 32'd0);
        chk("oow_err", 32'(err), 32'd0);
        @(posedge clock); #1;
        req_oe[1] = 1'b0;

        // oe and we together in-window: sticky error, nothing issued.
        req_addr[0 +: ADDR_W] = 14'd7;
        req_oe[0] = 1'b1;
        req_we[0] = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("conflict_err", 32'(err), 32'd1);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (mem_oe || mem_we || rsp_datardy != 2'b00) cnt++;
        end
        chk("conflict_strobes", cnt, 32'd0);
        @(posedge clock); #1;
        req_oe[0] = 1'b0;
        req_we[0] = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("err_sticky", 32'(err), 32'd1);

        // Reset during a channel-1 read wait.
        @(posedge clock); #1;
        req_addr[ADDR_W +: ADDR_W] = 14'd40;
        req_oe[1] = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("t5_issue", 32'(mem_oe), 32'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        chk("t5_rst_rsp", {14'd0, rsp_rdata, rsp_datardy}, 32'd0);
        chk("t5_rst_mem", {4'd0, mem_oe, mem_we, mem_addr, mem_wdata, mem_wmask}, 32'd0);
        chk("t5_rst_err", 32'(err), 32'd0);
        req_oe[1] = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (rsp_datardy != 2'b00) cnt++;
        end
        chk("t5_no_dr", cnt, 32'd0);
        @(posedge clock); #1;
        do_req(0, 0, 40, 8'h00, 4'd8);

`ifdef ARB_STATS_EN
        // Both channels writing back to back: strict alternation.
        reset_dut();
        chk("stat_rst", stat_grants0 | stat_grants1 | stat_wait0 | stat_wait1, 32'd0);
        shadow[100] = 8'h5A;
        shadow[101] = 8'h6C;
        e.rd = 1'b0; e.data = 8'h00;
        for (int k = 0; k < 6; k++) begin
            e.ch = k[0];
            sb.push_back(e);
        end
        req_addr  = {14'd101, 14'd100};
        req_wdata = 16'h6C5A;
        req_size  = 8'h88;
        req_we    = 2'b11;
        repeat (12) @(posedge clock);
        #1;
        req_we = 2'b00;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("alt_sb_drained", sb.size(), 32'd0);
        chk("stat_grants0", stat_grants0, 32'd3);
        chk("stat_grants1", stat_grants1, 32'd3);
        chk("stat_wait0_nz", 32'(stat_wait0 != 0), 32'd1);
        chk("stat_wait1_nz", 32'(stat_wait1 != 0), 32'd1);
        @(posedge clock); #1;
        do_req(1, 0, 100, 8'h00, 4'd8);
`endif

        repeat (2) @(negedge clock);
        chk("sb_final_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
